// File: rtl/bp_me_lce_req_latency_tracker_if.sv
// -----------------------------------------------------------------------------
// bp_me_lce_req_latency_tracker_if
//
// Purpose: bundles the two monitored LCE<->CCE handshakes into one interface.
//
// Handshake semantics (both channels): a transfer happens in a cycle where the
// valid and the ready/yumi are both high at the rising clock edge. Payload
// (type/addr) is only meaningful while valid is high. The tracker only
// observes these signals; it never drives them.
//
// Signals:
//   req_v_i          LCE->CCE request valid
//   req_ready_and_i  CCE ready for the request
//   req_type_i       0=RD miss, 1=WR miss, 2=UC_RD, 3=UC_WR
//   req_addr_i       request physical address
//   cmd_v_i          CCE->LCE command valid
//   cmd_yumi_i       LCE consumes the command
//   cmd_type_i       command type (5 DATA, 6 UC_DATA, 7 UC_ST_DONE, 9 ST_WAKEUP)
//   cmd_addr_i       command physical address
//
// Modports: master = side producing the bus activity (testbench / system),
//           slave  = the latency tracker (observer, all inputs).
// -----------------------------------------------------------------------------
interface bp_me_lce_req_latency_tracker_if #(
    parameter int paddr_width_p = 40
);
    logic                     req_v_i;
    logic                     req_ready_and_i;
    logic [1:0]               req_type_i;
    logic [paddr_width_p-1:0] req_addr_i;
    logic                     cmd_v_i;
    logic                     cmd_yumi_i;
    logic [3:0]               cmd_type_i;
    logic [paddr_width_p-1:0] cmd_addr_i;

    modport master (
        output req_v_i, req_ready_and_i, req_type_i, req_addr_i,
        output cmd_v_i, cmd_yumi_i, cmd_type_i, cmd_addr_i
    );

    modport slave (
        input req_v_i, req_ready_and_i, req_type_i, req_addr_i,
        input cmd_v_i, cmd_yumi_i, cmd_type_i, cmd_addr_i
    );
endinterface

// File: rtl/bp_me_lce_req_latency_tracker.sv
// -----------------------------------------------------------------------------
// bp_me_lce_req_latency_tracker
//
// Purpose: measures the latency of one outstanding LCE request at a time, from
// the cycle it is sent until the matching completion command is received, and
// keeps per-op statistics (count, latency sum), global max/last latency and a
// count of requests that crossed the timeout threshold.
//
// Ports:
//   clk_i        clock, rising edge
//   reset_i      asynchronous, active-low reset
//   bus_if       monitored request/command handshakes (slave modport)
//   clear_i      synchronous clear of all statistics (does not abort tracking)
//   stat_sel_i   0-3 count[op], 4-7 sum[op], 8 max, 9 last, 10 timeout count
//   stat_o       selected statistic, zero-extended, combinational
//   busy_o       a request is outstanding
//   timeout_o    sticky flag: outstanding request reached timeout_p cycles
//   o_dbg_state  current FSM state (0 = IDLE, 1 = WAIT)
// -----------------------------------------------------------------------------
module bp_me_lce_req_latency_tracker #(
    parameter int lat_width_p    = 32,
    parameter int sum_width_p    = 48,
    parameter int timeout_p      = 4096,
    parameter int paddr_width_p  = 40,
    parameter int block_offset_p = 6
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    bp_me_lce_req_latency_tracker_if.slave       bus_if,
    input  logic                                 clear_i,
    input  logic [3:0]                           stat_sel_i,
    output logic [63:0]                          stat_o,
    output logic                                 busy_o,
    output logic                                 timeout_o,
    output logic                                 o_dbg_state
);

    localparam int blk_width_lp = paddr_width_p - block_offset_p;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    state_e                    r_state;
    state_e                    w_state_next;

    logic [1:0]                r_op;
    logic [blk_width_lp-1:0]   r_blk_addr;
    logic [lat_width_p-1:0]    r_lat;
    logic                      r_to_flag;

    logic [lat_width_p-1:0]    r_count [4];
    logic [sum_width_p-1:0]    r_sum   [4];
    logic [lat_width_p-1:0]    r_max;
    logic [lat_width_p-1:0]    r_last;
    logic [lat_width_p-1:0]    r_to_count;

    logic                      w_send;
    logic                      w_recv;
    logic                      w_is_comp;
    logic                      w_addr_match;
    logic                      w_capture;
    logic                      w_complete;
    logic                      w_to_hit;
    logic [sum_width_p:0]      w_sum_ext;
    logic                      w_unused;

    assign w_send       = bus_if.req_v_i & bus_if.req_ready_and_i;
    assign w_recv       = bus_if.cmd_v_i & bus_if.cmd_yumi_i;
    assign w_addr_match = (bus_if.cmd_addr_i[paddr_width_p-1:block_offset_p] == r_blk_addr);

    // Address bits inside the block never take part in matching.
    assign w_unused = ^{bus_if.req_addr_i[block_offset_p-1:0],
                        bus_if.cmd_addr_i[block_offset_p-1:0]};

    always_comb begin
        w_is_comp = 1'b0;
        case (bus_if.cmd_type_i)
            4'h5, 4'h6, 4'h7, 4'h9: w_is_comp = 1'b1;
            default:                w_is_comp = 1'b0;
        endcase
    end

    // Only a completion seen while already in WAIT can close a request; a
    // completion coincident with the send (state still IDLE) is ignored.
    assign w_complete = (r_state == ST_WAIT) & w_recv & w_is_comp & w_addr_match;

    // r_lat can only equal timeout_p once per request unless the counter
    // saturates exactly there, so the sticky flag also gates the count.
    assign w_to_hit = (r_state == ST_WAIT) & (r_lat == lat_width_p'(timeout_p));

    // ---------------- FSM ----------------
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_send) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Sends while waiting are ignored: one request tracked at a time.
                if (w_complete) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ---------------- request capture and latency ----------------
    // Latency is loaded with 1 on send so that a completion k cycles after the
    // send cycle observes r_lat == k in its own cycle.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_op       <= 2'd0;
            r_blk_addr <= '0;
            r_lat      <= '0;
        end else if (w_capture) begin
            r_op       <= bus_if.req_type_i;
            r_blk_addr <= bus_if.req_addr_i[paddr_width_p-1:block_offset_p];
            r_lat      <= lat_width_p'(1);
        end else if (r_state == ST_WAIT) begin
            if (r_lat != '1) begin
                r_lat <= r_lat + lat_width_p'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_to_flag <= 1'b0;
        end else if ((r_state != ST_WAIT) || w_complete) begin
            r_to_flag <= 1'b0;
        end else if (w_to_hit) begin
            r_to_flag <= 1'b1;
        end
    end

    // ---------------- statistics ----------------
    // One extra bit catches accumulator overflow for saturation.
    assign w_sum_ext = {1'b0, r_sum[r_op]} + (sum_width_p + 1)'(r_lat);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < 4; i++) begin
                r_count[i] <= '0;
                r_sum[i]   <= '0;
            end
            r_max      <= '0;
            r_last     <= '0;
            r_to_count <= '0;
        end else if (clear_i) begin
            // Clear wins over a coincident completion or timeout event.
            for (int i = 0; i < 4; i++) begin
                r_count[i] <= '0;
                r_sum[i]   <= '0;
            end
            r_max      <= '0;
            r_last     <= '0;
            r_to_count <= '0;
        end else begin
            if (w_complete) begin
                if (r_count[r_op] != '1) begin
                    r_count[r_op] <= r_count[r_op] + lat_width_p'(1);
                end
                r_sum[r_op] <= w_sum_ext[sum_width_p] ? '1 : w_sum_ext[sum_width_p-1:0];
                if (r_lat > r_max) begin
                    r_max <= r_lat;
                end
                r_last <= r_lat;
            end
            if (w_to_hit && !r_to_flag && (r_to_count != '1)) begin
                r_to_count <= r_to_count + lat_width_p'(1);
            end
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        stat_o = '0;
        case (stat_sel_i)
            4'd0, 4'd1, 4'd2, 4'd3: stat_o = 64'(r_count[stat_sel_i[1:0]]);
            4'd4, 4'd5, 4'd6, 4'd7: stat_o = 64'(r_sum[stat_sel_i[1:0]]);
            4'd8:                   stat_o = 64'(r_max);
            4'd9:                   stat_o = 64'(r_last);
            4'd10:                  stat_o = 64'(r_to_count);
            default:                stat_o = '0;
        endcase
    end

    assign busy_o      = (r_state == ST_WAIT);
    assign timeout_o   = r_to_flag | w_to_hit;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bp_me_lce_req_latency_tracker.sv
module tb_bp_me_lce_req_latency_tracker;

  localparam int paddr_w = 40;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic reset_i;
  always #5 clk_i = ~clk_i;

  logic        clear_i;
  logic [3:0]  stat_sel_i;
  logic [63:0] stat_o;
  logic        busy_o;
  logic        timeout_o;
  logic        o_dbg_state;

  bp_me_lce_req_latency_tracker_if #(.paddr_width_p(paddr_w)) bus_if ();

  bp_me_lce_req_latency_tracker #(
    .lat_width_p   (32),
    .sum_width_p   (48),
    .timeout_p     (8),
    .paddr_width_p (paddr_w),
    .block_offset_p(6)
  ) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .bus_if     (bus_if),
    .clear_i    (clear_i),
    .stat_sel_i (stat_sel_i),
    .stat_o     (stat_o),
    .busy_o     (busy_o),
    .timeout_o  (timeout_o),
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // All tasks start and end at a falling edge; each call occupies whole cycles.
  task automatic bus_idle();
    bus_if.req_v_i         = 1'b0;
    bus_if.req_ready_and_i = 1'b0;
    bus_if.req_type_i      = 2'd0;
    bus_if.req_addr_i      = '0;
    bus_if.cmd_v_i         = 1'b0;
    bus_if.cmd_yumi_i      = 1'b0;
    bus_if.cmd_type_i      = 4'd0;
    bus_if.cmd_addr_i      = '0;
    clear_i                = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic send_req(input logic [1:0] t, input logic [paddr_w-1:0] a);
    bus_if.req_v_i         = 1'b1;
    bus_if.req_ready_and_i = 1'b1;
    bus_if.req_type_i      = t;
    bus_if.req_addr_i      = a;
    @(negedge clk_i);
    bus_idle();
  endtask

  task automatic send_cmd(input logic [3:0] t, input logic [paddr_w-1:0] a, input logic clr);
    bus_if.cmd_v_i    = 1'b1;
    bus_if.cmd_yumi_i = 1'b1;
    bus_if.cmd_type_i = t;
    bus_if.cmd_addr_i = a;
    clear_i           = clr;
    @(negedge clk_i);
    bus_idle();
  endtask

  task automatic send_both(input logic [1:0] rt, input logic [3:0] ct, input logic [paddr_w-1:0] a);
    bus_if.req_v_i         = 1'b1;
    bus_if.req_ready_and_i = 1'b1;
    bus_if.req_type_i      = rt;
    bus_if.req_addr_i      = a;
    bus_if.cmd_v_i         = 1'b1;
    bus_if.cmd_yumi_i      = 1'b1;
    bus_if.cmd_type_i      = ct;
    bus_if.cmd_addr_i      = a;
    @(negedge clk_i);
    bus_idle();
  endtask

  task automatic pulse_clear();
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
  endtask

  task automatic read_stat(input logic [3:0] sel, input logic [63:0] exp, input string tag);
    @(negedge clk_i);
    stat_sel_i = sel;
    #1;
    check(tag, stat_o, exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_i    = 1'b0;
    stat_sel_i = 4'd0;
    bus_idle();
    #1;
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_timeout", 64'(timeout_o), 64'd0);
    check("rst_state", 64'(o_dbg_state), 64'd0);
    read_stat(4'd0, 64'd0, "rst_count0");
    read_stat(4'd8, 64'd0, "rst_max");
    @(negedge clk_i);
    reset_i = 1'b1;
    idle_cycles(2);

    // RD miss 0x1000, DATA to 0x1020 (same block) 15 cycles later
    send_req(2'd0, 40'h1000);
    check("t1_busy", 64'(busy_o), 64'd1);
    check("t1_state", 64'(o_dbg_state), 64'd1);
    idle_cycles(14);
    send_cmd(4'h5, 40'h1020, 1'b0);
    check("t1_busy_low", 64'(busy_o), 64'd0);
    check("t1_timeout_low", 64'(timeout_o), 64'd0);
    read_stat(4'd0, 64'd1, "t1_count0");
    read_stat(4'd4, 64'd15, "t1_sum0");
    read_stat(4'd8, 64'd15, "t1_max");
    read_stat(4'd9, 64'd15, "t1_last");
    read_stat(4'd10, 64'd1, "t1_to_count");
    pulse_clear();
    read_stat(4'd4, 64'd0, "t1_clr_sum0");
    read_stat(4'd8, 64'd0, "t1_clr_max");

    // UC_WR 0x2000: non-completion type and wrong-block completion ignored
    send_req(2'd3, 40'h2000);
    send_cmd(4'h1, 40'h2000, 1'b0);
    idle_cycles(1);
    send_cmd(4'h7, 40'h3000, 1'b0);
    check("t2_busy_ignored", 64'(busy_o), 64'd1);
    idle_cycles(3);
    send_cmd(4'h7, 40'h2000, 1'b0);
    check("t2_busy_low", 64'(busy_o), 64'd0);
    read_stat(4'd3, 64'd1, "t2_count3");
    read_stat(4'd7, 64'd7, "t2_sum3");
    read_stat(4'd8, 64'd7, "t2_max");
    read_stat(4'd10, 64'd0, "t2_to_count");

    // WR miss, timeout at latency 8, ST_WAKEUP at latency 13
    send_req(2'd1, 40'h4000);
    idle_cycles(6);
    check("t3_timeout_lat7", 64'(timeout_o), 64'd0);
    idle_cycles(1);
    check("t3_timeout_lat8", 64'(timeout_o), 64'd1);
    idle_cycles(5);
    check("t3_timeout_sticky", 64'(timeout_o), 64'd1);
    send_cmd(4'h9, 40'h4000, 1'b0);
    check("t3_timeout_clr", 64'(timeout_o), 64'd0);
    check("t3_busy_low", 64'(busy_o), 64'd0);
    read_stat(4'd1, 64'd1, "t3_count1");
    read_stat(4'd5, 64'd13, "t3_sum1");
    read_stat(4'd8, 64'd13, "t3_max");
    read_stat(4'd10, 64'd1, "t3_to_count");

    // Second request during WAIT is ignored
    send_req(2'd0, 40'h5000);
    idle_cycles(1);
    send_req(2'd1, 40'h6000);
    idle_cycles(1);
    send_cmd(4'h5, 40'h6000, 1'b0);
    check("t4_busy_still", 64'(busy_o), 64'd1);
    send_cmd(4'h5, 40'h5000, 1'b0);
    check("t4_busy_low", 64'(busy_o), 64'd0);
    send_cmd(4'h5, 40'h6000, 1'b0);
    check("t4_idle_cmd", 64'(busy_o), 64'd0);
    read_stat(4'd0, 64'd1, "t4_count0");
    read_stat(4'd4, 64'd5, "t4_sum0");
    read_stat(4'd1, 64'd1, "t4_count1");
    read_stat(4'd9, 64'd5, "t4_last");
    read_stat(4'd8, 64'd13, "t4_max");

    // Completion coincident with the send is ignored
    send_both(2'd2, 4'h6, 40'h7000);
    check("t5_busy", 64'(busy_o), 64'd1);
    idle_cycles(2);
    send_cmd(4'h6, 40'h7000, 1'b0);
    read_stat(4'd2, 64'd1, "t5_count2");
    read_stat(4'd6, 64'd3, "t5_sum2");

    // Clear during WAIT does not abort the request
    send_req(2'd3, 40'h9000);
    pulse_clear();
    check("t6_busy_after_clr", 64'(busy_o), 64'd1);
    idle_cycles(1);
    send_cmd(4'h7, 40'h9000, 1'b0);
    read_stat(4'd3, 64'd1, "t6_count3");
    read_stat(4'd7, 64'd3, "t6_sum3");
    read_stat(4'd0, 64'd0, "t6_count0");
    read_stat(4'd8, 64'd3, "t6_max");

    // Reset pulse mid-WAIT discards the request
    send_req(2'd0, 40'hA000);
    idle_cycles(2);
    reset_i = 1'b0;
    #1;
    check("t7_busy_rst", 64'(busy_o), 64'd0);
    check("t7_timeout_rst", 64'(timeout_o), 64'd0);
    read_stat(4'd3, 64'd0, "t7_count3_rst");
    read_stat(4'd7, 64'd0, "t7_sum3_rst");
    @(negedge clk_i);
    reset_i = 1'b1;
    send_cmd(4'h5, 40'hA000, 1'b0);
    check("t7_busy_after", 64'(busy_o), 64'd0);
    for (int s = 0; s <= 10; s++) read_stat(4'(s), 64'd0, "t7_stat_zero");

    // Clear coincident with a completion
    send_req(2'd1, 40'hB000);
    idle_cycles(1);
    send_cmd(4'h9, 40'hB000, 1'b0);
    read_stat(4'd1, 64'd1, "t8_count1_pre");
    send_req(2'd0, 40'h8000);
    idle_cycles(1);
    send_cmd(4'h5, 40'h8000, 1'b1);
    check("t8_busy_low", 64'(busy_o), 64'd0);
    for (int s = 0; s <= 10; s++) read_stat(4'(s), 64'd0, "t8_stat_clr");
    read_stat(4'd15, 64'd0, "t8_sel15");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bp_me_lce_req_latency_tracker.md
BP_ME_LCE_REQ_LATENCY_TRACKER -- requirements
Module: bp_me_lce_req_latency_tracker

Interface
REQ-001 The block SHALL have parameter lat_width_p, default 32, the width of the latency counter, max register and per-op count registers.
REQ-002 The block SHALL have parameter sum_width_p, default 48, the width of the per-op latency accumulators.
REQ-003 The block SHALL have parameter timeout_p, default 4096, the latency in cycles at which an outstanding request is flagged.
REQ-004 The block SHALL have parameter paddr_width_p, default 40, the physical address width.
REQ-005 The block SHALL have parameter block_offset_p, default 6, the number of address LSBs ignored on match (64 B block).
REQ-006 clk_i  input  1  clock; all state updates on the rising edge.
REQ-007 reset_i  input  1  reset, asynchronous, active-low.
REQ-008 req_v_i  input  1  LCE request valid at the LCE->CCE request port.
REQ-009 req_ready_and_i  input  1  CCE ready; a request is sent when req_v_i & req_ready_and_i.
REQ-010 req_type_i  input  2  0=RD miss, 1=WR miss, 2=UC_RD, 3=UC_WR.
REQ-011 req_addr_i  input  paddr_width_p  request address.
REQ-012 cmd_v_i  input  1  CCE->LCE command valid.
REQ-013 cmd_yumi_i  input  1  LCE consumes the command; a command is received when cmd_v_i & cmd_yumi_i.
REQ-014 cmd_type_i  input  4  command type; completion codes: 4'h5 DATA, 4'h6 UC_DATA, 4'h7 UC_ST_DONE, 4'h9 ST_WAKEUP.
REQ-015 cmd_addr_i  input  paddr_width_p  command address.
REQ-016 clear_i  input  1  synchronous clear of all statistics.
REQ-017 stat_sel_i  input  4  statistic select: 0-3 count[op], 4-7 sum[op], 8 max latency, 9 last latency, 10 timeout count; others read 0.
REQ-018 stat_o  output  64  selected statistic, zero-extended, combinational from stat_sel_i.
REQ-019 busy_o  output  1  high while a request is outstanding.
REQ-020 timeout_o  output  1  sticky, high once the outstanding request's latency reaches timeout_p.

Function
REQ-021 The FSM SHALL have states IDLE and WAIT; reset state SHALL be IDLE.
REQ-022 In IDLE, a sent request SHALL capture req_type_i and req_addr_i[paddr_width_p-1:block_offset_p], load latency to 1 and enter WAIT the next cycle.
REQ-023 In WAIT, the latency SHALL increment by 1 per cycle, saturating at all-ones.
REQ-024 In WAIT, a received completion command SHALL return the FSM to IDLE only if cmd_type_i is a completion code and its block address equals the captured block address.
REQ-025 On completion, the latency SHALL include the completion cycle: a request sent in cycle N and completed in cycle N+k SHALL record latency k.
REQ-026 On completion, count[op] SHALL increment by 1, sum[op] SHALL add latency, max SHALL take max(max, latency) and last SHALL take latency, all saturating at their widths.
REQ-027 Non-matching or non-completion commands in WAIT SHALL be ignored.
REQ-028 A request sent while in WAIT SHALL be ignored; only one request is tracked at a time.
REQ-029 A completion in the cycle the FSM is in IDLE SHALL be ignored, including one coincident with a request send.
REQ-030 timeout_o SHALL rise the cycle latency equals timeout_p while in WAIT, and the timeout count SHALL increment once per request.
REQ-031 timeout_o SHALL clear on return to IDLE.
REQ-032 busy_o SHALL equal (state == WAIT).
REQ-033 clear_i SHALL zero all statistics but SHALL NOT abort an outstanding request.
REQ-034 clear_i coincident with a completion SHALL take priority: the statistics SHALL read zero the next cycle.

Reset
REQ-035 While reset_i is low, the state SHALL be IDLE, all counters, accumulators, max, last and timeout count SHALL be 0, and busy_o and timeout_o SHALL be 0.
REQ-036 Reset assertion mid-request SHALL discard the outstanding request without updating statistics.
REQ-037 The first request tracked after reset deassertion SHALL be the first send occurring in a cycle where reset_i is high.

Verification
REQ-038 RD miss to 0x1000 sent in cycle 10, DATA to 0x1020 in cycle 25 -> count[0]=1, sum[0]=15, max=15, last=15, busy_o low from cycle 26.
REQ-039 UC_WR to 0x2000, then UC_ST_DONE to 0x3000, then UC_ST_DONE to 0x2000 after 7 cycles -> first ignored, count[3]=1, sum[3]=7.
REQ-040 timeout_p=8, WR miss with no completion -> timeout_o high at latency 8, timeout count=1; ST_WAKEUP later -> timeout_o low, count[1]=1.
REQ-041 Second request sent during WAIT, then completions for both addresses -> only the first request is counted.
REQ-042 reset_i pulsed low mid-WAIT, then a completion -> busy_o=0, all stat_o reads 0.
REQ-043 clear_i coincident with a completion -> all stat_o selects read 0 next cycle; unmapped stat_sel_i=15 -> 0.
